countdown_controller: RTL and testbench

- Traffic-light controller for a highway / country-road intersection.
- The highway is green by default; a car sensor on the country road requests a crossing.
- An internal prescaler turns the system clock into a 1-per-CLK_FREQ-cycle "tick".
- All phase timing is counted in ticks. The remaining time of the current phase is exported for a countdown display.

---
 rtl/countdown_controller.sv | 142 ++++++++++++++
 tb/tb_countdown_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/countdown_controller.sv
// ---------------------------------------------------------------------------
// countdown_controller
//   Traffic-light controller for a highway / country-road intersection.
//   The highway holds green by default. A country-road car sensor requests a
//   crossing, which is granted only once the highway has been green for at
//   least T ticks. A prescaler divides clk into a one-cycle tick every
//   CLK_FREQ cycles, and all phase timing is counted in those ticks.
//
// Parameters
//   CLK_FREQ    clk cycles per tick (>= 1)
//   COUNT_BITS  width of current_count (must hold max(T,t)-1)
//   T           green duration in ticks (>= 1)
//   t           yellow duration in ticks (>= 1)
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-low reset
//   car            in   country-road car present (level, clk-synchronous)
//   current_count  out  ticks remaining in current phase minus 1
//   highway_gry    out  highway lamps, one-hot {green, red, yellow}
//   country_gry    out  country lamps, one-hot {green, red, yellow}
// ---------------------------------------------------------------------------
module countdown_controller #(
    parameter int unsigned CLK_FREQ   = 100_000,
    parameter int unsigned COUNT_BITS = 4,
    parameter int unsigned T          = 10,
    parameter int unsigned t          = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  car,
    output logic [COUNT_BITS-1:0] current_count,
    output logic [2:0]            highway_gry,
    output logic [2:0]            country_gry
);

    // A 1-bit prescaler is kept when CLK_FREQ == 1; it simply stays at 0.
    localparam int unsigned PRESC_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

    localparam logic [2:0] LAMP_GREEN  = 3'b100;
    localparam logic [2:0] LAMP_RED    = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;

    localparam logic [COUNT_BITS-1:0] GREEN_LOAD  = COUNT_BITS'(T - 1);
    localparam logic [COUNT_BITS-1:0] YELLOW_LOAD = COUNT_BITS'(t - 1);

    typedef enum logic [1:0] {
        S_HG = 2'd0,
        S_HY = 2'd1,
        S_CG = 2'd2,
        S_CY = 2'd3
    } state_t;

    logic [PRESC_W-1:0]    r_presc;
    logic [PRESC_W-1:0]    w_presc_nxt;
    logic                  w_tick;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [COUNT_BITS-1:0] r_count;
    logic [COUNT_BITS-1:0] w_count_nxt;
    logic [2:0]            r_highway_gry;
    logic [2:0]            r_country_gry;
    logic [2:0]            w_highway_nxt;
    logic [2:0]            w_country_nxt;

    // Prescaler: counts 0..CLK_FREQ-1, tick on the terminal value.
    assign w_tick      = (r_presc == PRESC_W'(CLK_FREQ - 1));
    assign w_presc_nxt = w_tick ? '0 : (r_presc + PRESC_W'(1));

    // State, countdown and lamp registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc       <= '0;
            r_state       <= S_HG;
            r_count       <= GREEN_LOAD;
            r_highway_gry <= LAMP_GREEN;
            r_country_gry <= LAMP_RED;
        end else begin
            r_presc       <= w_presc_nxt;
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_highway_gry <= w_highway_nxt;
            r_country_gry <= w_country_nxt;
        end
    end

    // Next state and countdown; everything holds on non-tick cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (w_tick) begin
            if (r_count != '0) begin
                w_count_nxt = r_count - COUNT_BITS'(1);
            end else begin
                unique case (r_state)
                    // Highway stays green at count 0 until a car is seen on a tick.
                    S_HG: begin
                        if (car) begin
                            w_state_nxt = S_HY;
                            w_count_nxt = YELLOW_LOAD;
                        end
                    end
                    S_HY: begin
                        w_state_nxt = S_CG;
                        w_count_nxt = GREEN_LOAD;
                    end
                    S_CG: begin
                        w_state_nxt = S_CY;
                        w_count_nxt = YELLOW_LOAD;
                    end
                    S_CY: begin
                        w_state_nxt = S_HG;
                        w_count_nxt = GREEN_LOAD;
                    end
                    default: begin
                        w_state_nxt = S_HG;
                        w_count_nxt = GREEN_LOAD;
                    end
                endcase
            end
        end
    end

    // Lamp decode of the next state, so the lamp registers always track r_state.
    always_comb begin
        w_highway_nxt = LAMP_RED;
        w_country_nxt = LAMP_RED;
        unique case (w_state_nxt)
            S_HG:    w_highway_nxt = LAMP_GREEN;
            S_HY:    w_highway_nxt = LAMP_YELLOW;
            S_CG:    w_country_nxt = LAMP_GREEN;
            S_CY:    w_country_nxt = LAMP_YELLOW;
            default: w_highway_nxt = LAMP_RED;
        endcase
    end

    assign current_count = r_count;
    assign highway_gry   = r_highway_gry;
    assign country_gry   = r_country_gry;

endmodule

// File: tb/tb_countdown_controller.sv
// ---------------------------------------------------------------------------
// tb_countdown_controller
//   Directed bench for countdown_controller with CLK_FREQ=4, T=10, t=3.
//   Outputs are sampled 1 time unit after the rising clock edge.
// ---------------------------------------------------------------------------
module tb_countdown_controller;

    localparam int unsigned CLK_FREQ = 4;
    localparam int unsigned CB       = 4;

    logic          clk;
    logic          rst;
    logic          car;
    logic [CB-1:0] current_count;
    logic [2:0]    highway_gry;
    logic [2:0]    country_gry;

    int n_checks;
    int n_fail;

    countdown_controller #(
        .CLK_FREQ  (CLK_FREQ),
        .COUNT_BITS(CB),
        .T         (10),
        .t         (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .car          (car),
        .current_count(current_count),
        .highway_gry  (highway_gry),
        .country_gry  (country_gry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n ticks; lands 1 unit after the tick edge.
    task automatic tick_wait(input int n);
        repeat (n * CLK_FREQ) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [CB-1:0] cnt,
                               input logic [2:0] hw, input logic [2:0] cw);
        check_eq({tag, "_cnt"}, 32'(current_count), 32'(cnt));
        check_eq({tag, "_hw"},  32'(highway_gry),  32'(hw));
        check_eq({tag, "_cw"},  32'(country_gry),  32'(cw));
    endtask

    task automatic check_invariants(input string tag);
        check_eq({tag, "_red"},  32'(highway_gry[1] | country_gry[1]), 32'd1);
        check_eq({tag, "_hw1h"}, 32'($countones(highway_gry)), 32'd1);
        check_eq({tag, "_cw1h"}, 32'($countones(country_gry)), 32'd1);
    endtask

    initial begin
        int            p;
        logic [CB-1:0] e_cnt;
        logic [2:0]    e_hw;
        logic [2:0]    e_cw;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        car      = 1'b0;

        // Held in reset.
        repeat (3) @(posedge clk);
        #1;
        check_state("reset", 4'd9, 3'b100, 3'b010);

        // Release; first decrement 4 clocks later.
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_tick_cnt", 32'(current_count), 32'd9);
        @(posedge clk);
        #1;
        check_eq("first_tick_cnt", 32'(current_count), 32'd8);

        // No car: count down to 0 then hold in HG.
        for (int k = 7; k >= 0; k--) begin
            tick_wait(1);
            check_state("nocar_down", 4'(k), 3'b100, 3'b010);
        end
        for (int k = 0; k < 21; k++) begin
            tick_wait(1);
            check_state("nocar_hold", 4'd0, 3'b100, 3'b010);
        end

        // Car request at HG count 0.
        car = 1'b1;
        tick_wait(1);
        check_state("req_hy", 4'd2, 3'b001, 3'b010);
        tick_wait(3);
        check_state("req_cg", 4'd9, 3'b010, 3'b100);
        tick_wait(10);
        check_state("req_cy", 4'd2, 3'b010, 3'b001);
        tick_wait(3);
        check_state("req_hg", 4'd9, 3'b100, 3'b010);

        // Car held: 26-tick cycle HG(10) HY(3) CG(10) CY(3).
        for (int i = 1; i <= 100; i++) begin
            tick_wait(1);
            p = i % 26;
            if (p < 10) begin
                e_cnt = 4'(9 - p);  e_hw = 3'b100; e_cw = 3'b010;
            end else if (p < 13) begin
                e_cnt = 4'(12 - p); e_hw = 3'b001; e_cw = 3'b010;
            end else if (p < 23) begin
                e_cnt = 4'(22 - p); e_hw = 3'b010; e_cw = 3'b100;
            end else begin
                e_cnt = 4'(25 - p); e_hw = 3'b010; e_cw = 3'b001;
            end
            check_state("cycle", e_cnt, e_hw, e_cw);
            check_invariants("cycle");
        end
        // 100 % 26 = 22 -> CG at count 0.
        car = 1'b0;
        tick_wait(1);
        check_state("drop_cy", 4'd2, 3'b010, 3'b001);
        tick_wait(3);
        check_state("drop_hg", 4'd9, 3'b100, 3'b010);

        // Early car at HG count 5: minimum green still honoured.
        tick_wait(4);
        check_state("early_c5", 4'd5, 3'b100, 3'b010);
        car = 1'b1;
        tick_wait(5);
        check_state("early_c0", 4'd0, 3'b100, 3'b010);
        tick_wait(1);
        check_state("early_hy", 4'd2, 3'b001, 3'b010);

        // Mid-operation reset during CG at count 4, mid tick period.
        tick_wait(3);
        check_state("mid_cg", 4'd9, 3'b010, 3'b100);
        tick_wait(5);
        check_state("mid_cg4", 4'd4, 3'b010, 3'b100);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_state("async_rst", 4'd9, 3'b100, 3'b010);
        car = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst2_pre_tick", 32'(current_count), 32'd9);
        @(posedge clk);
        #1;
        check_state("rst2_tick", 4'd8, 3'b100, 3'b010);
        tick_wait(8);
        check_state("rst2_c0", 4'd0, 3'b100, 3'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
